// File: rtl/game_ctrl_if.sv
// Game controller bus: debounced buttons, collision and score in; state and display controls out.
interface game_ctrl_if;
   localparam int unsigned SCORE_W = 14;

   logic               btn_start;
   logic               btn_mode;
   logic               collision;
   logic [SCORE_W-1:0] score;
   logic [1:0]         game_state;
   logic               mode;
   logic [1:0]         speed;
   logic               lockout;

   modport master (
      output btn_start, btn_mode, collision, score,
      input  game_state, mode, speed, lockout
   );

   modport slave (
      input  btn_start, btn_mode, collision, score,
      output game_state, mode, speed, lockout
   );
endinterface

// File: rtl/game_ctrl.sv
// Game flow controller: INIT/START/END/RESET sequencing, end-of-game lockout, display mode and speed.
// Optional macro GAME_CTRL_AUTO_ALT_EN: mode alternates automatically every ALT_PERIOD ticks in GAME_END.
module game_ctrl #(
   parameter int unsigned END_LOCKOUT = 36,
   parameter int unsigned ALT_PERIOD  = 72
) (
   input  logic        game_clk,
   input  logic        rst,
   game_ctrl_if.slave  bus
);
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned SCORE_W = 14;

   localparam logic [CNT_W-1:0]   LOCK_MAX  = CNT_W'(END_LOCKOUT);
   localparam logic [SCORE_W-1:0] SCORE_T1  = SCORE_W'(100);
   localparam logic [SCORE_W-1:0] SCORE_T2  = SCORE_W'(300);
   localparam logic [SCORE_W-1:0] SCORE_T3  = SCORE_W'(600);

   if (END_LOCKOUT < 1 || END_LOCKOUT > 255) begin : g_bad_lockout
      $error("game_ctrl: END_LOCKOUT must be 1..255");
   end
   if (ALT_PERIOD < 1 || ALT_PERIOD > 255) begin : g_bad_alt
      $error("game_ctrl: ALT_PERIOD must be 1..255");
   end

   typedef enum logic [1:0] {
      GAME_INIT  = 2'd0,
      GAME_START = 2'd1,
      GAME_END   = 2'd2,
      GAME_RESET = 2'd3
   } state_t;

   state_t           state;
   logic             start_prev;
   logic             mode_prev;
   logic             start_armed;
   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] lock_cnt_inc;
   logic             mode_r;
   logic [1:0]       speed_r;
   logic             lockout_r;
   logic             start_edge;
   logic             mode_edge;
   logic [1:0]       tier;

`ifdef GAME_CTRL_AUTO_ALT_EN
   localparam logic [CNT_W-1:0] ALT_LAST = CNT_W'(ALT_PERIOD - 1);
   logic [CNT_W-1:0] alt_cnt;
`endif

   // A start press only counts once the button has been seen released since reset.
   assign start_edge = bus.btn_start & ~start_prev & start_armed;
   assign mode_edge  = bus.btn_mode & ~mode_prev;
   assign lock_cnt_inc = (lock_cnt < LOCK_MAX) ? lock_cnt + CNT_W'(1) : lock_cnt;

   always_comb begin
      tier = 2'd3;
      if (bus.score < SCORE_T1)      tier = 2'd0;
      else if (bus.score < SCORE_T2) tier = 2'd1;
      else if (bus.score < SCORE_T3) tier = 2'd2;
   end

   always_ff @(posedge game_clk or posedge rst) begin
      if (rst) begin
         state       <= GAME_INIT;
         start_prev  <= 1'b0;
         mode_prev   <= 1'b0;
         start_armed <= 1'b0;
         lock_cnt    <= '0;
         mode_r      <= 1'b0;
         speed_r     <= 2'd0;
         lockout_r   <= 1'b0;
`ifdef GAME_CTRL_AUTO_ALT_EN
         alt_cnt     <= '0;
`endif
      end else begin
         start_prev <= bus.btn_start;
         mode_prev  <= bus.btn_mode;
         if (!bus.btn_start) start_armed <= 1'b1;

         case (state)
            GAME_INIT: begin
               speed_r   <= 2'd0;
               lockout_r <= 1'b0;
               if (start_edge) begin
                  state  <= GAME_START;
                  mode_r <= 1'b0;
               end else if (mode_edge) begin
                  mode_r <= ~mode_r;
               end
            end

            GAME_START: begin
               mode_r  <= 1'b0;
               speed_r <= (tier > speed_r) ? tier : speed_r;
               if (bus.collision) begin
                  state     <= GAME_END;
                  lock_cnt  <= '0;
                  lockout_r <= (LOCK_MAX != '0);
`ifdef GAME_CTRL_AUTO_ALT_EN
                  alt_cnt   <= '0;
`endif
               end else begin
                  lockout_r <= 1'b0;
               end
            end

            GAME_END: begin
               // Presses during lockout are dropped, not remembered.
               if (start_edge && !lockout_r) begin
                  state     <= GAME_RESET;
                  mode_r    <= 1'b0;
                  speed_r   <= 2'd0;
                  lockout_r <= 1'b0;
               end else begin
                  lock_cnt  <= lock_cnt_inc;
                  lockout_r <= (lock_cnt_inc < LOCK_MAX);
`ifdef GAME_CTRL_AUTO_ALT_EN
                  if (alt_cnt == ALT_LAST) begin
                     alt_cnt <= '0;
                     mode_r  <= ~mode_r;
                  end else begin
                     alt_cnt <= alt_cnt + CNT_W'(1);
                  end
`else
                  if (mode_edge) mode_r <= ~mode_r;
`endif
               end
            end

            GAME_RESET: begin
               state     <= GAME_START;
               mode_r    <= 1'b0;
               speed_r   <= 2'd0;
               lockout_r <= 1'b0;
            end

            default: state <= GAME_INIT;
         endcase
      end
   end

   assign bus.game_state = state;
   assign bus.mode       = mode_r;
   assign bus.speed      = speed_r;
   assign bus.lockout    = lockout_r;
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed steps queue expected outputs, a monitor compares each tick.
module tb_game_ctrl;
   localparam int unsigned LOCK = 36;
   localparam int unsigned ALT  = 4;
   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_END   = 2'd2;
   localparam logic [1:0] S_RST   = 2'd3;

   logic game_clk = 1'b0;
   logic rst      = 1'b0;

   game_ctrl_if bus ();

   game_ctrl #(.END_LOCKOUT(LOCK), .ALT_PERIOD(ALT)) dut (
      .game_clk (game_clk),
      .rst      (rst),
      .bus      (bus.slave)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [1:0] st;
      logic       md;
      logic [1:0] sp;
      logic       lk;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   always #5 game_clk = ~game_clk;
   always @(posedge game_clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [1:0] st, input logic md,
                      input logic [1:0] sp, input logic lk);
      checks++;
      if (bus.game_state !== st || bus.mode !== md || bus.speed !== sp || bus.lockout !== lk) begin
         failures++;
         $display("FAIL %s @cyc %0d: got state=%0d mode=%0d speed=%0d lockout=%0d, want state=%0d mode=%0d speed=%0d lockout=%0d",
                  name, cyc, bus.game_state, bus.mode, bus.speed, bus.lockout, st, md, sp, lk);
      end
   endtask

   // Monitor: compare every expectation due at this tick, flag any that were skipped.
   initial begin
      exp_t e;
      forever begin
         @(posedge game_clk);
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL %s: expectation for cyc %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else begin
               cmp(e.name, e.st, e.md, e.sp, e.lk);
            end
         end
      end
   end

   task automatic step(input string name, input logic bs, input logic bm, input logic co,
                       input logic [13:0] sc, input logic [1:0] st, input logic md,
                       input logic [1:0] sp, input logic lk);
      exp_t e;
      @(negedge game_clk);
      bus.btn_start = bs;
      bus.btn_mode  = bm;
      bus.collision = co;
      bus.score     = sc;
      e.cyc  = cyc + 1;
      e.name = name;
      e.st   = st;
      e.md   = md;
      e.sp   = sp;
      e.lk   = lk;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 10) begin
         @(posedge game_clk);
         #2;
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s: %0d expectations still pending", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic       bs;
      logic       bm;
      logic       md;
      bus.btn_start = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.collision = 1'b0;
      bus.score     = 14'd0;

      #1 rst = 1'b1;
      #2 cmp("reset_async", S_INIT, 1'b0, 2'd0, 1'b0);
      @(negedge game_clk);
      @(negedge game_clk);
      rst = 1'b0;

      // Idle in INIT, mode toggles on edges only, then start.
      for (int i = 0; i < 4; i++) step("init_idle", 0, 0, 0, 0, S_INIT, 0, 2'd0, 0);
      step("init_mode_edge",  0, 1, 0, 0, S_INIT, 1, 2'd0, 0);
      step("init_mode_hold",  0, 1, 0, 0, S_INIT, 1, 2'd0, 0);
      step("init_mode_low",   0, 0, 0, 0, S_INIT, 1, 2'd0, 0);
      step("init_mode_edge2", 0, 1, 0, 0, S_INIT, 0, 2'd0, 0);
      step("init_start_edge", 1, 0, 0, 14'd99, S_START, 0, 2'd0, 0);

      // Speed tiers and no decrease.
      step("spd_99",      1, 0, 0, 14'd99,  S_START, 0, 2'd0, 0);
      step("spd_100",     1, 0, 0, 14'd100, S_START, 0, 2'd1, 0);
      step("spd_300",     1, 0, 0, 14'd300, S_START, 0, 2'd2, 0);
      step("spd_600",     1, 0, 0, 14'd600, S_START, 0, 2'd3, 0);
      step("spd_no_drop", 0, 0, 0, 14'd50,  S_START, 0, 2'd3, 0);

      // Collision wins over a simultaneous start edge.
      step("coll_and_start", 1, 0, 1, 14'd50, S_END, 0, 2'd3, 1);

      // Lockout window: presses at 10 and 35 dropped, press at 40 restarts.
      for (int n = 1; n < 40; n++) begin
         bs = (n == 10 || n == 35);
`ifdef GAME_CTRL_AUTO_ALT_EN
         md = ((n / 4) % 2) == 1;
`else
         md = 1'b0;
`endif
         step($sformatf("end_tick_%0d", n), bs, 0, 0, 14'd50, S_END, md, 2'd3, (n < 36));
      end
      step("end_start_accept", 1, 0, 0, 14'd50, S_RST,   0, 2'd0, 0);
      step("reset_to_start",   0, 0, 0, 14'd50, S_START, 0, 2'd0, 0);

      // Second game: mode behaviour in END.
      step("score_350", 0, 0, 0, 14'd350, S_START, 0, 2'd2, 0);
      step("coll2",     0, 0, 1, 14'd350, S_END,   0, 2'd2, 1);
      for (int n = 1; n <= 20; n++) begin
         bm = (n == 2 || n == 3 || n == 7);
`ifdef GAME_CTRL_AUTO_ALT_EN
         md = ((n / 4) % 2) == 1;
`else
         md = (n >= 2 && n < 7);
`endif
         step($sformatf("end2_mode_%0d", n), 0, bm, 0, 14'd350, S_END, md, 2'd2, 1);
      end
`ifdef GAME_CTRL_AUTO_ALT_EN
      md = 1'b1;
`else
      md = 1'b0;
`endif
      step("end2_locked_press", 1, 0, 0, 14'd350, S_END, md, 2'd2, 1);
      drain("drain_before_rst");

      // Asynchronous reset mid-END with start held; needs a fresh 0->1 afterwards.
      @(negedge game_clk);
      #2 rst = 1'b1;
      #1 cmp("rst_mid_end", S_INIT, 1'b0, 2'd0, 1'b0);
      @(negedge game_clk);
      @(negedge game_clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step("held_after_rst", 1, 0, 0, 14'd350, S_INIT, 0, 2'd0, 0);
      step("release_after_rst", 0, 0, 0, 14'd350, S_INIT,  0, 2'd0, 0);
      step("fresh_press",       1, 0, 0, 14'd350, S_START, 0, 2'd0, 0);
      step("start_speed",       1, 0, 0, 14'd350, S_START, 0, 2'd2, 0);
      drain("drain_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
